// File: rtl/heavyhash_mv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// heavyhash_pkg
// Shared constants and types for the HeavyHash matrix-vector sequencer.
// The matrix is NROW x NCOL nibbles and is processed NPE rows at a time.
// Each pass walks NBEAT memory beats of four columns per PE.
// ---------------------------------------------------------------------------
package heavyhash_pkg;

  // Array geometry. The defaults give 4 passes of 16 beats.
  localparam int NPE    = 16;
  localparam int NROW   = 64;
  localparam int NCOL   = 64;
  localparam int NBEAT  = NCOL / 4;
  localparam int NPASS  = NROW / NPE;
  localparam int AW     = $clog2(NPASS * NBEAT);
  localparam int BEAT_W = $clog2(NBEAT);
  localparam int PASS_W = $clog2(NPASS);

  // Bus widths. A memory beat carries four nibbles for each PE.
  localparam int NIB_W = 4;
  localparam int VEC_W = NCOL * NIB_W;
  localparam int RES_W = NROW * NIB_W;
  localparam int X_W   = 4 * NIB_W;
  localparam int M_W   = NPE * X_W;

  // PE accumulator format. Bits [13:10] of the row sum are the result
  // nibble, so the low ten bits are discarded.
  localparam int PE_ACC_W = 14;
  localparam int OUT_MSB  = 13;
  localparam int OUT_LSB  = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    WAIT,
    MAC,
    DRAIN,
    CAP,
    DONE
  } state_t;

endpackage

// File: rtl/heavyhash_mv_ctrl_if.sv
// ---------------------------------------------------------------------------
// heavyhash_mv_ctrl_if
// Job-level handshakes of the sequencer.
//   in_valid / in_ready / in_vec    : 256-bit SHA3 vector in (element j = in_vec[4j+3:4j])
//   res_valid / res_ready / res_vec : 256-bit product vector out (row r = res_vec[4r+3:4r])
// The slave modport is the sequencer. The master modport is whoever feeds it
// and consumes the result.
// ---------------------------------------------------------------------------
interface heavyhash_mv_ctrl_if;
  import heavyhash_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_vec;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_vec;

  modport master (
    output in_valid, in_vec, res_ready,
    input  in_ready, res_valid, res_vec
  );

  modport slave (
    input  in_valid, in_vec, res_ready,
    output in_ready, res_valid, res_vec
  );

endinterface

// File: rtl/heavyhash_mv_ctrl.sv
// ---------------------------------------------------------------------------
// heavyhash_mv_ctrl
// Sequencer for the HeavyHash PE array. For each accepted vector it runs
// NPASS passes over the matrix memory. Each pass clears the PEs, streams
// NBEAT beats of matrix data and vector slices into them, and captures bits
// [13:10] of every accumulator into the result vector.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   job_if         : vector-in / result-out handshakes (slave side)
//   mat_rd_en_o    : matrix memory read strobe (data returns one cycle later)
//   mat_addr_o     : pass*NBEAT + beat
//   mat_rdata_i    : NPE x 16-bit row slices for the current beat
//   pe_clr_o       : PE accumulator clear (all PEs)
//   pe_en_o        : PE multiply-accumulate enable (all PEs)
//   pe_m_o         : per-PE matrix operand
//   pe_x_o         : broadcast vector operand
//   pe_out_i       : NPE x 14-bit accumulators
//   busy_o         : a job is in flight
// ---------------------------------------------------------------------------
module heavyhash_mv_ctrl
  import heavyhash_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  heavyhash_mv_ctrl_if.slave        job_if,
  output logic                      mat_rd_en_o,
  output logic [AW-1:0]             mat_addr_o,
  input  logic [M_W-1:0]            mat_rdata_i,
  output logic                      pe_clr_o,
  output logic                      pe_en_o,
  output logic [M_W-1:0]            pe_m_o,
  output logic [X_W-1:0]            pe_x_o,
  input  logic [NPE*PE_ACC_W-1:0]   pe_out_i,
  output logic                      busy_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(NBEAT - 1);
  localparam logic [BEAT_W-1:0] PRELAST_BEAT = BEAT_W'(NBEAT - 2);
  localparam logic [PASS_W-1:0] LAST_PASS    = PASS_W'(NPASS - 1);

  state_t              state_q;
  logic [PASS_W-1:0]   pass_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [VEC_W-1:0]    vec_q;
  logic [RES_W-1:0]    resVec_q;
  logic                inReady_q;
  logic                resValid_q;
  logic                busy_q;
  logic                peClr_q;
  logic                peEn_q;
  logic                matRdEn_q;
  logic [AW-1:0]       matAddr_q;
  logic                unusedAccBits;

  // Sequencer FSM, pass/beat counters and result capture in one process.
  // Every control output is registered and updated on the edge that enters
  // the state it belongs to, so it is glitch-free for the whole state.
  // Because memory data arrives one cycle after the strobe, the read for
  // beat b+1 is issued while beat b is being consumed. WAIT issues the read
  // for beat 0, and MAC stops issuing reads once the last beat is in flight.
  // DRAIN keeps pe_en high for one extra cycle so the PE product register
  // folds its last product into the accumulator before CAP samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      beat_q      <= '0;
      vec_q       <= '0;
      resVec_q    <= '0;
      inReady_q   <= 1'b1;
      resValid_q  <= 1'b0;
      busy_q      <= 1'b0;
      peClr_q     <= 1'b0;
      peEn_q      <= 1'b0;
      matRdEn_q   <= 1'b0;
      matAddr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_if.in_valid && inReady_q) begin
            vec_q     <= job_if.in_vec;
            pass_q    <= '0;
            beat_q    <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            peClr_q   <= 1'b1;
            state_q   <= CLR;
          end
        end

        CLR: begin
          peClr_q   <= 1'b0;
          matRdEn_q <= 1'b1;
          matAddr_q <= {pass_q, BEAT_W'(0)};
          beat_q    <= '0;
          state_q   <= WAIT;
        end

        WAIT: begin
          peEn_q    <= 1'b1;
          matRdEn_q <= 1'b1;
          matAddr_q <= {pass_q, BEAT_W'(1)};
          state_q   <= MAC;
        end

        MAC: begin
          if (beat_q == LAST_BEAT) begin
            beat_q  <= '0;
            state_q <= DRAIN;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q < PRELAST_BEAT) begin
              matRdEn_q <= 1'b1;
              matAddr_q <= {pass_q, beat_q + BEAT_W'(2)};
            end else begin
              matRdEn_q <= 1'b0;
              matAddr_q <= '0;
            end
          end
        end

        DRAIN: begin
          peEn_q  <= 1'b0;
          state_q <= CAP;
        end

        CAP: begin
          for (int i = 0; i < NPE; i++) begin
            resVec_q[(int'(pass_q) * NPE + i) * NIB_W +: NIB_W] <=
              pe_out_i[i * PE_ACC_W + OUT_LSB +: NIB_W];
          end
          if (pass_q == LAST_PASS) begin
            resValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            pass_q  <= pass_q + PASS_W'(1);
            peClr_q <= 1'b1;
            state_q <= CLR;
          end
        end

        DONE: begin
          if (job_if.res_ready) begin
            resValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Operand mux. Memory data is only meaningful in MAC, and it arrives the
  // same cycle it is consumed, so the mux is combinational from the
  // registered state. Both operands are held at zero in every other state
  // so that no stale product reaches an accumulator.
  always_comb begin
    pe_m_o = '0;
    pe_x_o = '0;
    if (state_q == MAC) begin
      pe_m_o = mat_rdata_i;
      pe_x_o = vec_q[int'(beat_q) * X_W +: X_W];
    end
  end

  // The accumulator bits below the result nibble are never needed. Folding
  // them here shows they are dropped on purpose.
  always_comb begin
    unusedAccBits = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      unusedAccBits = unusedAccBits ^ (^pe_out_i[i * PE_ACC_W +: OUT_LSB]);
    end
  end

  // Drive the registered state onto the ports.
  assign job_if.in_ready  = inReady_q;
  assign job_if.res_valid = resValid_q;
  assign job_if.res_vec   = resVec_q;
  assign mat_rd_en_o      = matRdEn_q;
  assign mat_addr_o       = matAddr_q;
  assign pe_clr_o         = peClr_q;
  assign pe_en_o          = peEn_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_heavyhash_mv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_heavyhash_mv_ctrl
// Directed bench for the HeavyHash sequencer. A behavioural matrix memory
// with one-cycle read latency and behavioural PEs sit around the DUT. Each
// PE has a delayed clear, a one-cycle product register and a 14-bit
// accumulator. Expected result vectors are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_heavyhash_mv_ctrl;
  import heavyhash_pkg::*;

  localparam logic [RES_W-1:0] ALL_E   = {64{4'hE}};
  localparam logic [VEC_W-1:0] ALL_F   = {64{4'hF}};
  localparam logic [VEC_W-1:0] ALL_1   = {64{4'h1}};
  localparam logic [RES_W-1:0] RAMP_15 = {4{64'hEDCBA98765432100}};
  localparam int               JOB_LAT = 80;

  logic                     clk = 1'b0;
  logic                     rstN;
  logic                     matRdEn;
  logic [AW-1:0]            matAddr;
  logic [M_W-1:0]           matRdata = '0;
  logic                     peClr;
  logic                     peEn;
  logic [M_W-1:0]           peM;
  logic [X_W-1:0]           peX;
  logic [NPE*PE_ACC_W-1:0]  peOut;
  logic                     busy;

  logic [3:0]               matrix [NROW][NCOL];
  logic [PE_ACC_W-1:0]      acc    [NPE];
  logic [9:0]               prod   [NPE];
  logic                     clrDly = 1'b0;
  logic                     enDly  = 1'b0;

  logic                     capArm = 1'b0;
  logic                     prevEn = 1'b0;
  int                       capCount;
  int                       capBad;
  int                       capExpect;

  int                       compareCount  = 0;
  int                       mismatchCount = 0;

  heavyhash_mv_ctrl_if jobBus ();

  heavyhash_mv_ctrl dut (
    .clk         (clk),
    .rst_n       (rstN),
    .job_if      (jobBus.slave),
    .mat_rd_en_o (matRdEn),
    .mat_addr_o  (matAddr),
    .mat_rdata_i (matRdata),
    .pe_clr_o    (peClr),
    .pe_en_o     (peEn),
    .pe_m_o      (peM),
    .pe_x_o      (peX),
    .pe_out_i    (peOut),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Four-nibble dot product, as one PE computes it per beat.
  function automatic logic [9:0] nibbleDot(input logic [15:0] m, input logic [15:0] x);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(m[k*4 +: 4]) * int'(x[k*4 +: 4]);
    return 10'(s);
  endfunction

  // Matrix memory: the data for the strobed address shows up one cycle later.
  // Slice i carries row pass*NPE+i, columns 4*beat .. 4*beat+3.
  always @(posedge clk) begin
    if (matRdEn) begin
      for (int i = 0; i < NPE; i++) begin
        for (int k = 0; k < 4; k++) begin
          matRdata[i*16 + k*4 +: 4] <=
            matrix[int'(matAddr[AW-1:BEAT_W]) * NPE + i][int'(matAddr[BEAT_W-1:0]) * 4 + k];
        end
      end
    end
  end

  // PE array model. The clear takes effect one cycle late, like the DSP
  // reset. The product is registered for a cycle before it is accumulated.
  always @(posedge clk) begin
    clrDly <= peClr;
    enDly  <= peEn;
    for (int i = 0; i < NPE; i++) begin
      prod[i] <= peEn ? nibbleDot(peM[i*16 +: 16], peX) : 10'd0;
      if (clrDly)
        acc[i] <= '0;
      else if (enDly)
        acc[i] <= acc[i] + {4'd0, prod[i]};
    end
  end

  always_comb begin
    peOut = '0;
    for (int i = 0; i < NPE; i++) peOut[i*PE_ACC_W +: PE_ACC_W] = acc[i];
  end

  // While armed, look at every accumulator in each CAP cycle. CAP is the
  // cycle in which pe_en has just dropped after DRAIN.
  always @(negedge clk) begin
    if (capArm && prevEn && !peEn) begin
      capCount = capCount + 1;
      for (int i = 0; i < NPE; i++) begin
        if (int'(acc[i]) != capExpect) capBad = capBad + 1;
      end
    end
    prevEn = peEn;
  end

  // Hard stop in case something escapes every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point. All checks are counted here.
  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load one of the test matrices into the memory model.
  task automatic fillMatrix(input int kind);
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        case (kind)
          0:       matrix[r][c] = 4'hF;
          1:       matrix[r][c] = 4'h0;
          2:       matrix[r][c] = (c < 4) ? 4'hF : 4'h0;
          default: matrix[r][c] = 4'(r % 16);
        endcase
      end
    end
  endtask

  // Present one vector and return just after the accepting edge. Afterwards
  // the input bus carries a different vector, so any late re-sampling of
  // in_vec would corrupt the result.
  task automatic applyStimulus(input string tag, input logic [VEC_W-1:0] vec);
    @(negedge clk);
    checkOutput({tag, " in_ready before accept"}, 256'(jobBus.in_ready), 256'(1));
    jobBus.in_valid = 1'b1;
    jobBus.in_vec   = vec;
    @(posedge clk);
    #1;
    jobBus.in_valid = 1'b0;
    jobBus.in_vec   = ~vec;
  endtask

  // Wait (bounded) for res_valid. Check the accept-to-valid latency and
  // the product vector.
  task automatic awaitResult(input string tag, input logic [RES_W-1:0] exp);
    int cycles;
    cycles = 0;
    while (!jobBus.res_valid && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, " latency"}, 256'(cycles), 256'(JOB_LAT));
    checkOutput({tag, " res_vec"}, jobBus.res_vec, exp);
  endtask

  // One-cycle res_ready handshake, then the DUT must be back in IDLE.
  task automatic releaseResult(input string tag);
    jobBus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    jobBus.res_ready = 1'b0;
    checkOutput({tag, " res_valid after ready"}, 256'(jobBus.res_valid), 256'(0));
    checkOutput({tag, " in_ready after ready"}, 256'(jobBus.in_ready), 256'(1));
    checkOutput({tag, " busy after ready"}, 256'(busy), 256'(0));
  endtask

  // Every output must show its reset value.
  task automatic checkReset(input string tag);
    checkOutput({tag, " in_ready"}, 256'(jobBus.in_ready), 256'(1));
    checkOutput({tag, " res_valid"}, 256'(jobBus.res_valid), 256'(0));
    checkOutput({tag, " res_vec"}, jobBus.res_vec, 256'(0));
    checkOutput({tag, " busy"}, 256'(busy), 256'(0));
    checkOutput({tag, " pe_clr"}, 256'(peClr), 256'(0));
    checkOutput({tag, " pe_en"}, 256'(peEn), 256'(0));
    checkOutput({tag, " mat_rd_en"}, 256'(matRdEn), 256'(0));
    checkOutput({tag, " pe_m"}, 256'(peM), 256'(0));
    checkOutput({tag, " pe_x"}, 256'(peX), 256'(0));
  endtask

  // Main directed sequence.
  initial begin
    for (int i = 0; i < NPE; i++) begin
      acc[i]  = '0;
      prod[i] = '0;
    end
    jobBus.in_valid  = 1'b0;
    jobBus.in_vec    = '0;
    jobBus.res_ready = 1'b0;
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #10;
    checkReset("power-on");
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] all-15 matrix, all-15 vector");
    fillMatrix(0);
    applyStimulus("all15", ALL_F);
    awaitResult("all15", ALL_E);
    releaseResult("all15");

    $display("[TB] columns 0..3 only, accumulator check at CAP");
    fillMatrix(2);
    capCount  = 0;
    capBad    = 0;
    capExpect = 900;
    capArm    = 1'b1;
    applyStimulus("cols0to3", ALL_F);
    awaitResult("cols0to3", '0);
    capArm = 1'b0;
    checkOutput("cols0to3 CAP cycles seen", 256'(capCount), 256'(NPASS));
    checkOutput("cols0to3 accumulators not 900", 256'(capBad), 256'(0));
    releaseResult("cols0to3");

    $display("[TB] back-to-back jobs, all-15 then all-0 matrix");
    fillMatrix(0);
    applyStimulus("b2b first", ALL_F);
    awaitResult("b2b first", ALL_E);
    releaseResult("b2b first");
    fillMatrix(1);
    applyStimulus("b2b second", ALL_F);
    awaitResult("b2b second", '0);
    releaseResult("b2b second");

    $display("[TB] result stalled 50 cycles");
    fillMatrix(0);
    applyStimulus("stall", ALL_F);
    awaitResult("stall", ALL_E);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      checkOutput("stall res_valid", 256'(jobBus.res_valid), 256'(1));
      checkOutput("stall res_vec", jobBus.res_vec, ALL_E);
      checkOutput("stall in_ready", 256'(jobBus.in_ready), 256'(0));
    end
    releaseResult("stall");

    $display("[TB] reset at pass 2 beat 7");
    applyStimulus("midreset", ALL_F);
    repeat (49) @(posedge clk);
    #1;
    checkOutput("midreset pe_en in MAC", 256'(peEn), 256'(1));
    checkOutput("midreset mat_rd_en", 256'(matRdEn), 256'(1));
    checkOutput("midreset mat_addr", 256'(matAddr), 256'(40));
    checkOutput("midreset pe_x", 256'(peX), 256'(16'hFFFF));
    checkOutput("midreset pe_m", 256'(peM), 256'({NPE{16'hFFFF}}));
    #2 rstN = 1'b0;
    #1;
    checkReset("midreset async");
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus("after reset", ALL_F);
    awaitResult("after reset", ALL_E);
    releaseResult("after reset");

    $display("[TB] row r = r mod 16 matrix");
    fillMatrix(3);
    applyStimulus("ramp x1", ALL_1);
    awaitResult("ramp x1", '0);
    releaseResult("ramp x1");
    applyStimulus("ramp x15", ALL_F);
    awaitResult("ramp x15", RAMP_15);
    releaseResult("ramp x15");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
